shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_pkg.sv | 14 +
 rtl/shift_dp.sv | 30 +++
 rtl/shift_seq_ctrl.sv | 103 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and default sizing for the shift sequencer controller.
package shift_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_STEP  = 16;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/shift_dp.sv
// Word register with a load/shift mux; fill enters at the low end on each shift.
module shift_dp #(
    parameter int WIDTH = 32,
    parameter int STEP  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    input  logic [STEP-1:0]  fill,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] word_q;

    // Load wins over shift so a fresh request always starts from in_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= d;
        end else if (shift) begin
            word_q <= {word_q[WIDTH-STEP-1:0], fill};
        end
    end

    assign q = word_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer: accepts a word, applies in_count STEP-bit shifts, then holds the result until taken.
import shift_seq_pkg::*;

module shift_seq_ctrl #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [STEP-1:0]  in_fill,
    input  logic [CNT_W-1:0] in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [STEP-1:0]  fill_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] word;

    assign load  = in_ready_q && in_valid;
    assign shift = (state_q == SHIFT);

    shift_dp #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_dp (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .d     (in_data),
        .fill  (fill_q),
        .q     (word)
    );

    // Handshake flags are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fill_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        fill_q     <= in_fill;
                        cnt_q      <= in_count;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (in_count == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_valid_q ? word : '0;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed, table-driven bench for shift_seq_ctrl at WIDTH=32, STEP=16.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [15:0] in_fill;
    logic [5:0]  in_count;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [31:0] data;
        logic [15:0] fill;
        logic [5:0]  count;
        logic [31:0] expData;
        int          expLat;
    } vec_t;

    vec_t vecs[6];

    shift_seq_ctrl #(
        .WIDTH (32),
        .STEP  (16),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_fill   (in_fill),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Wait (bounded) for out_valid; lat counts cycles since the accept edge.
    task automatic waitForValid(output int lat, output logic busyOk);
        lat    = 1;
        busyOk = 1'b1;
        while (!out_valid && lat < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) busyOk = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b1 || in_ready !== 1'b0) busyOk = 1'b0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_post_data"}, out_data, 32'd0);
        checkOutput({tag, "_post_ready"}, {31'd0, in_ready}, 32'd1);
        checkOutput({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int   lat;
        logic busyOk;
        @(negedge clk);
        checkOutput({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = v.data;
        in_fill  = v.fill;
        in_count = v.count;
        @(negedge clk);
        // Scramble inputs after accept; the in-flight operation must not notice.
        in_valid = 1'b0;
        in_data  = ~v.data;
        in_fill  = ~v.fill;
        in_count = 6'd7;
        waitForValid(lat, busyOk);
        checkOutput({tag, "_latency"}, lat, v.expLat);
        checkOutput({tag, "_data"}, out_data, v.expData);
        checkOutput({tag, "_busy"}, {31'd0, busyOk}, 32'd1);
        handshake(tag);
    endtask

    initial begin
        int          lat;
        logic        busyOk;
        logic        stableOk;
        logic        quietOk;
        logic [31:0] held;

        vecs[0] = '{32'h12345678, 16'hABCD, 6'd1,  32'h5678ABCD, 2};
        vecs[1] = '{32'h12345678, 16'hABCD, 6'd0,  32'h12345678, 1};
        vecs[2] = '{32'h12345678, 16'hABCD, 6'd3,  32'hABCDABCD, 4};
        vecs[3] = '{32'hDEADBEEF, 16'h0001, 6'd2,  32'h00010001, 3};
        vecs[4] = '{32'hCAFEF00D, 16'h1234, 6'd1,  32'hF00D1234, 2};
        vecs[5] = '{32'h00000000, 16'hFFFF, 6'd63, 32'hFFFFFFFF, 64};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_fill   = '0;
        in_count  = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_data", out_data, 32'd0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 5 cycles while a new request is offered.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h11112222;
        in_fill  = 16'h3333;
        in_count = 6'd1;
        @(negedge clk);
        in_data  = 32'h99999999;
        in_count = 6'd0;
        waitForValid(lat, busyOk);
        checkOutput("bp_data", out_data, 32'h22223333);
        held     = out_data;
        stableOk = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stableOk = 1'b0;
        end
        checkOutput("bp_stable", {31'd0, stableOk}, 32'd1);
        in_valid = 1'b0;
        handshake("bp");
        @(negedge clk);
        checkOutput("bp_not_queued", {30'd0, busy, out_valid}, 32'd0);

        // Reset in the middle of a count-5 shift sequence.
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        in_fill  = 16'hABCD;
        in_count = 6'd5;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstmid_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstmid_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
        quietOk = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) quietOk = 1'b0;
        end
        checkOutput("rstmid_no_result", {31'd0, quietOk}, 32'd1);

        // Reset while a result is waiting in DONE.
        in_valid = 1'b1;
        in_count = 6'd0;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("rstdone_pre_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstdone_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstdone_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back with in_valid held high throughout.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0000FFFF;
        in_fill  = 16'h1111;
        in_count = 6'd1;
        @(negedge clk);
        in_data  = 32'h89ABCDEF;
        in_fill  = 16'h5A5A;
        in_count = 6'd1;
        waitForValid(lat, busyOk);
        checkOutput("b2b_a_latency", lat, 2);
        checkOutput("b2b_a_data", out_data, 32'hFFFF1111);
        checkOutput("b2b_a_busy", {31'd0, busyOk}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("b2b_gap_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("b2b_gap_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("b2b_b_accepted", {31'd0, busy}, 32'd1);
        waitForValid(lat, busyOk);
        checkOutput("b2b_b_latency", lat, 2);
        checkOutput("b2b_b_data", out_data, 32'hCDEF5A5A);
        handshake("b2b_b");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
